// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM encoding and width for the load/store unit.
package lsu_pkg;
  localparam int WORD_W = 32;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_MERGE  = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    return we ? (f3 inside {F3_B, F3_H, F3_W}) : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: request/response handshakes and word-RAM port of the load/store unit.
interface lsu_if;
  import lsu_pkg::*;
  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_funct3;
  logic [WORD_W-1:0] req_addr, req_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [WORD_W-1:0] rsp_rdata;
  logic [WORD_W-1:0] ram_addr, ram_wr_data, ram_rd_data;
  logic              ram_wr_sig;
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, ram_rd_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_wr_sig, ram_wr_data
  );
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, ram_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_wr_sig, ram_wr_data
  );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extract/extend for loads and lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [WORD_W-1:0] wdata,
  input  logic [1:0]        lo,
  input  logic [2:0]        funct3,
  output logic [WORD_W-1:0] ld_data,
  output logic [WORD_W-1:0] st_data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    ld_data = funct3 == F3_B  ? {{24{b[7]}}, b} :
              funct3 == F3_BU ? {24'b0, b} :
              funct3 == F3_H  ? {{16{h[15]}}, h} :
              funct3 == F3_HU ? {16'b0, h} : word;
    st_data = word;
    if (funct3 == F3_B) st_data[{lo, 3'b000} +: 8] = wdata[7:0];
    else if (funct3 == F3_H) st_data[{lo[1], 4'b0000} +: 16] = wdata[15:0];
    else st_data = wdata;
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit with sign/zero extension and read-modify-write sub-word stores.
// Define LSU_ALIGN_CHECK_EN to report misaligned halfword/word accesses as errors.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input logic   clk,
  input logic   reset_n,
  lsu_if.slave  bus
);
  localparam logic [WORD_W:0] ADDR_LIM = (WORD_W + 1)'(MEM_WORDS) << 2;
  logic [1:0]        state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        lo_q;
  logic [WORD_W-1:0] rdata_q, addr_q, wr_data_q, ld_data, st_data;
  logic              err_q, misal, req_err;
  always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
    misal = ((bus.req_funct3 == F3_H || bus.req_funct3 == F3_HU) && bus.req_addr[0]) ||
            (bus.req_funct3 == F3_W && bus.req_addr[1:0] != 2'b00);
`else
    misal = 1'b0;
`endif
    req_err = !f3_legal(bus.req_we, bus.req_funct3) || misal || ({1'b0, bus.req_addr} >= ADDR_LIM);
  end
  lsu_lane_align u_lane (
    .word    (bus.ram_rd_data),
    .wdata   (wr_data_q),
    .lo      (lo_q),
    .funct3  (f3_q),
    .ld_data (ld_data),
    .st_data (st_data)
  );
  // wr_data_q first holds the store operand, then the merged word for SB/SH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      lo_q      <= 2'b00;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.req_valid) begin
          we_q    <= bus.req_we;
          f3_q    <= bus.req_funct3;
          lo_q    <= bus.req_addr[1:0];
          rdata_q <= '0;
          err_q   <= req_err;
          if (!req_err) begin
            addr_q <= {bus.req_addr[WORD_W-1:2], 2'b00};
            if (bus.req_we) wr_data_q <= bus.req_wdata;
          end
          state <= req_err ? ST_RESP : ST_ACCESS;
        end
        ST_ACCESS: begin
          if (!we_q) rdata_q <= ld_data;
          else if (f3_q != F3_W) wr_data_q <= st_data;
          state <= (we_q && f3_q != F3_W) ? ST_MERGE : ST_RESP;
        end
        ST_MERGE: state <= ST_RESP;
        default: if (bus.rsp_ready) state <= ST_IDLE;
      endcase
    end
  end
  assign bus.req_ready   = state == ST_IDLE;
  assign bus.rsp_valid   = state == ST_RESP;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.ram_addr    = addr_q;
  assign bus.ram_wr_data = wr_data_q;
  assign bus.ram_wr_sig  = (state == ST_ACCESS && we_q && f3_q == F3_W) || state == ST_MERGE;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized and directed checks of lsu_ctrl against an arithmetic memory model.
module tb_lsu_ctrl;
`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam int MEMW = 1024;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int passed = 0;
  int wr_cnt = 0;
  logic [31:0] mem [0:MEMW-1];
  logic [31:0] ref_mem [0:MEMW-1];
  lsu_if bus ();
  lsu_ctrl #(.MEM_WORDS(MEMW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  always #5 clk = ~clk;
  assign bus.ram_rd_data = mem[bus.ram_addr[11:2]];
  always @(posedge clk) if (bus.ram_wr_sig === 1'b1) begin
    mem[bus.ram_addr[11:2]] = bus.ram_wr_data;
    wr_cnt = wr_cnt + 1;
  end

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] r, output logic e, output int lat, output int nw);
    int unsigned sb, sh, idx;
    logic [31:0] w, v;
    bit legal, mis;
    legal = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    mis = ALIGN && (((f3 == 1 || f3 == 5) && a % 2 != 0) || (f3 == 2 && a % 4 != 0));
    e = !legal || mis || a >= MEMW * 4;
    r = 0; lat = 1; nw = 0;
    if (!e) begin
      idx = a / 4; sb = 8 * (a % 4); sh = 16 * ((a / 2) % 2);
      w = ref_mem[idx];
      lat = 2;
      if (!we) begin
        if (f3 == 0 || f3 == 4) begin
          v = (w >> sb) & 32'hFF;
          r = (f3 == 0 && v >= 128) ? v - 32'd256 : v;
        end else if (f3 == 1 || f3 == 5) begin
          v = (w >> sh) & 32'hFFFF;
          r = (f3 == 1 && v >= 32768) ? v - 32'd65536 : v;
        end else r = w;
      end else begin
        nw = 1;
        if (f3 == 2) ref_mem[idx] = wd;
        else begin
          lat = 3;
          if (f3 == 0) ref_mem[idx] = (w & ~(32'hFF << sb)) | ((wd & 32'hFF) << sb);
          else ref_mem[idx] = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        end
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input string nm);
    logic [31:0] er;
    logic ee;
    int el, ew, lat, w0;
    model(we, f3, a, wd, er, ee, el, ew);
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) $display("FAIL %s req_ready got %b want 1", nm, bus.req_ready); else passed++;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
    w0 = wr_cnt;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (bus.rsp_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
    checks++; if (lat != el) $display("FAIL %s latency got %0d want %0d", nm, lat, el); else passed++;
    checks++; if (bus.rsp_rdata !== er) $display("FAIL %s rdata got %h want %h", nm, bus.rsp_rdata, er); else passed++;
    checks++; if (bus.rsp_err !== ee) $display("FAIL %s err got %b want %b", nm, bus.rsp_err, ee); else passed++;
    checks++; if (wr_cnt - w0 != ew) $display("FAIL %s writes got %0d want %0d", nm, wr_cnt - w0, ew); else passed++;
    if (we) begin
      checks++; if (mem[a[11:2]] !== ref_mem[a[11:2]]) $display("FAIL %s ram word got %h want %h", nm, mem[a[11:2]], ref_mem[a[11:2]]); else passed++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.ram_wr_sig} !== 4'b1000) $display("FAIL reset ctrl got %b want 1000", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.ram_wr_sig}); else passed++;
    checks++; if ({bus.rsp_rdata, bus.ram_addr, bus.ram_wr_data} !== 96'd0) $display("FAIL reset data got %h want 0", {bus.rsp_rdata, bus.ram_addr, bus.ram_wr_data}); else passed++;
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) $display("FAIL reset release got %b%b want 10", bus.req_ready, bus.rsp_valid); else passed++;
  endtask

  task automatic test_word_and_extend;
    do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, "sw_10");
    do_req(0, 3'b010, 32'h10, 0, "lw_10");
    checks++; if (bus.rsp_rdata !== 32'hDEADBEEF) $display("FAIL lw_10_const got %h want deadbeef", bus.rsp_rdata); else passed++;
    do_req(0, 3'b000, 32'h13, 0, "lb_13");
    do_req(0, 3'b100, 32'h13, 0, "lbu_13");
    do_req(0, 3'b001, 32'h10, 0, "lh_10");
    do_req(0, 3'b101, 32'h12, 0, "lhu_12");
  endtask

  task automatic test_rmw;
    do_req(1, 3'b000, 32'h11, 32'hFFFFFF55, "sb_11");
    do_req(0, 3'b010, 32'h10, 0, "lw_after_sb");
    checks++; if (bus.rsp_rdata !== 32'hDEAD55EF) $display("FAIL sb_const got %h want dead55ef", bus.rsp_rdata); else passed++;
    do_req(1, 3'b001, 32'h12, 32'hABCD1234, "sh_12");
    do_req(0, 3'b010, 32'h10, 0, "lw_after_sh");
    checks++; if (bus.rsp_rdata !== 32'h123455EF) $display("FAIL sh_const got %h want 123455ef", bus.rsp_rdata); else passed++;
  endtask

  task automatic test_errors;
    do_req(0, 3'b010, 32'h0E, 0, "lw_0e");
    do_req(1, 3'b001, 32'h01, 32'h7777, "sh_01");
    do_req(0, 3'b010, 32'h1000, 0, "lw_oor");
    do_req(1, 3'b010, 32'hFFFF_FFFC, 32'h1, "sw_oor");
    do_req(0, 3'b011, 32'h20, 0, "ld_f3_3");
    do_req(1, 3'b100, 32'h20, 32'h5, "st_f3_4");
    do_req(1, 3'b011, 32'h20, 32'h5, "st_f3_3");
    do_req(0, 3'b111, 32'h20, 0, "ld_f3_7");
  endtask

  task automatic test_backpressure;
    logic [31:0] er;
    logic ee;
    int el, ew, lat, w0;
    model(0, 3'b010, 32'h10, 0, er, ee, el, ew);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h10;
    @(posedge clk); #1;
    bus.req_we = 1'b1; bus.req_addr = 32'h40; bus.req_wdata = 32'h0BAD_0BAD;
    w0 = wr_cnt;
    lat = 1;
    @(negedge clk);
    while (bus.rsp_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
    checks++; if (lat != 2) $display("FAIL bp latency got %0d want 2", lat); else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== er || bus.req_ready !== 1'b0)
        $display("FAIL bp hold%0d got v=%b d=%h rr=%b want v=1 d=%h rr=0", i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, er);
      else passed++;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) $display("FAIL bp release got rr=%b v=%b want 1 0", bus.req_ready, bus.rsp_valid); else passed++;
    checks++; if (wr_cnt != w0 || mem[16] !== ref_mem[16]) $display("FAIL bp ignored store writes=%0d word=%h want 0 %h", wr_cnt - w0, mem[16], ref_mem[16]); else passed++;
  endtask

  task automatic test_reset_midop;
    logic [31:0] keep;
    keep = ref_mem[8];
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000; bus.req_addr = 32'h21; bus.req_wdata = 32'hAA;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.ram_wr_sig !== 1'b1) $display("FAIL midop merge wr_sig got %b want 1", bus.ram_wr_sig); else passed++;
    reset_n = 1'b0;
    #1;
    checks++; if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.ram_wr_sig} !== 4'b1000) $display("FAIL midop ctrl got %b want 1000", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.ram_wr_sig}); else passed++;
    checks++; if ({bus.rsp_rdata, bus.ram_addr, bus.ram_wr_data} !== 96'd0) $display("FAIL midop data got %h want 0", {bus.rsp_rdata, bus.ram_addr, bus.ram_wr_data}); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    checks++; if (mem[8] !== keep) $display("FAIL midop ram word got %h want %h", mem[8], keep); else passed++;
    do_req(0, 3'b010, 32'h20, 0, "lw_after_reset");
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, MEMW * 4 - 1));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, "rand");
    end
  endtask

  initial begin
    for (int i = 0; i < MEMW; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000; bus.req_addr = 0; bus.req_wdata = 0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_word_and_extend();
    test_rmw();
    test_errors();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
